// File: rtl/calc_result_display_pkg.sv
// Shared types and constants for the calculator result display: FSM states,
// register widths, the seven-segment glyph table and the double-dabble step.
package calc_disp_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 8;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int SR_W   = BCD_W + BIN_W;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment patterns {g,f,e,d,c,b,a}, element 0 is the glyph for digit 0
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] adj;
        adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[BIN_W + 4*d +: 4] >= 4'd5)
                adj[BIN_W + 4*d +: 4] = adj[BIN_W + 4*d +: 4] + 4'd3;
        end
        return {adj[SR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/calc_result_display_if.sv
// Bundle of the result-capture handshake and the display pins between the
// calculator core side (master) and the display block (slave).
interface calc_result_display_if;
    import calc_disp_pkg::*;

    logic [BIN_W-1:0]  result_in;
    logic              load;
    logic              busy;
    logic [BCD_W-1:0]  bcd;
    logic              bcd_valid;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_en;

    modport master (
        output result_in, load,
        input  busy, bcd, bcd_valid, seg, dig_en
    );

    modport slave (
        input  result_in, load,
        output busy, bcd, bcd_valid, seg, dig_en
    );

endinterface

// File: rtl/calc_result_display_seg7_decode.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes show blank.
module seg7_decode
    import calc_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9)
            seg = SEG_TABLE[digit];
    end

endmodule

// File: rtl/calc_result_display.sv
// Captures an 8-bit result, converts it to BCD one shift per clock and scans
// the three digits onto a multiplexed seven-segment display.
module calc_result_display
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 1024,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    calc_result_display_if.slave  bus
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] R_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    state_t            state;
    logic [2:0]        iter;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_next;
    logic [BCD_W-1:0]  bcd_r;
    logic              valid_r;

    logic [RW-1:0]     refresh_cnt;
    logic [1:0]        scan_idx;
    logic [3:0]        digit;
    logic              blank;
    logic [6:0]        dec_seg;
    logic [6:0]        seg_raw;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] dig_en_q;

    assign sr_next = dabble_step(sr);

    // bcd_r is only written on the final shift, so partial results never escape
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            iter    <= 3'd0;
            sr      <= '0;
            bcd_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        sr    <= {{BCD_W{1'b0}}, bus.result_in};
                        iter  <= 3'd0;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr   <= sr_next;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        bcd_r   <= sr_next[SR_W-1:BIN_W];
                        valid_r <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
        end else if (refresh_cnt == R_LAST) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        digit = bcd_r[3:0];
        blank = !valid_r;
        case (scan_idx)
            2'd1: begin
                digit = bcd_r[7:4];
                if (BLANK_LEADING != 0 && bcd_r[11:4] == 8'h00)
                    blank = 1'b1;
            end
            2'd2: begin
                digit = bcd_r[11:8];
                if (BLANK_LEADING != 0 && bcd_r[11:8] == 4'h0)
                    blank = 1'b1;
            end
            default: ;
        endcase
    end

    seg7_decode u_decode (
        .digit (digit),
        .seg   (dec_seg)
    );

    assign seg_raw = blank ? SEG_BLANK : dec_seg;

    // Both display outputs come from the same scan index on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q    <= SEG_BLANK ^ SEG_XOR;
            dig_en_q <= 3'b001;
        end else begin
            seg_q    <= seg_raw ^ SEG_XOR;
            dig_en_q <= 3'b001 << scan_idx;
        end
    end

    assign bus.busy      = (state == CONVERT);
    assign bus.bcd       = bcd_r;
    assign bus.bcd_valid = valid_r;
    assign bus.seg       = seg_q;
    assign bus.dig_en    = dig_en_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Self-checking bench: three display instances (blanking / active-low / no blanking)
// share one stimulus stream; conversions are scored against a queue of expected BCD.
module tb_calc_result_display;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    calc_result_display_if bus_a ();
    calc_result_display_if bus_b ();
    calc_result_display_if bus_c ();

    calc_result_display #(.REFRESH_DIV(4), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a));
    calc_result_display #(.REFRESH_DIV(4), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b));
    calc_result_display #(.REFRESH_DIV(3), .BLANK_LEADING(0), .SEG_ACTIVE_LOW(0)) dut_c (
        .clk (clk), .rst (rst), .bus (bus_c));

    typedef struct {
        logic [7:0]  value;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t        vecs [10];
    logic [6:0]  seg_tab [10];
    logic [11:0] exp_q [$];
    logic [11:0] last_bcd;
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v, input logic l);
        bus_a.result_in = v; bus_a.load = l;
        bus_b.result_in = v; bus_b.load = l;
        bus_c.result_in = v; bus_c.load = l;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int idx_of(input logic [2:0] de);
        case (de)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] b, input int idx, input bit bl,
                                           input bit al, input bit valid);
        logic [3:0] d;
        bit         blk;
        logic [6:0] s;
        d   = b[4*idx +: 4];
        blk = !valid
              || (bl && idx == 2 && b[11:8] == 4'h0)
              || (bl && idx == 1 && b[11:4] == 8'h00);
        s   = blk ? 7'h00 : seg_tab[d];
        return al ? ~s : s;
    endfunction

    task automatic check_disp_dut(input string name, input logic [2:0] de, input logic [6:0] sg,
                                  input logic [11:0] b, input bit bl, input bit al, input bit valid);
        int idx;
        idx = idx_of(de);
        check_output({name, "_dig_onehot"}, 32'(idx >= 0), 32'd1);
        if (idx >= 0)
            check_output({name, "_seg"}, 32'(sg), 32'(exp_seg(b, idx, bl, al, valid)));
    endtask

    task automatic track_rot(input string name, input logic [2:0] de, inout logic [2:0] prev,
                             inout int dwell, inout int changes, input int div);
        if (de == prev) begin
            dwell++;
        end else begin
            check_output({name, "_scan_order"}, 32'(de), 32'({prev[1:0], prev[2]}));
            if (changes > 0)
                check_output({name, "_scan_dwell"}, 32'(dwell), 32'(div));
            changes++;
            dwell = 1;
            prev  = de;
        end
    endtask

    task automatic check_display(input logic [11:0] b, input bit valid);
        logic [2:0] prev_a, prev_c;
        int dwell_a, dwell_c, chg_a, chg_c;
        tick();
        tick();
        prev_a = bus_a.dig_en; prev_c = bus_c.dig_en;
        dwell_a = 1; dwell_c = 1; chg_a = 0; chg_c = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_disp_dut("a", bus_a.dig_en, bus_a.seg, b, 1'b1, 1'b0, valid);
            check_disp_dut("b", bus_b.dig_en, bus_b.seg, b, 1'b1, 1'b1, valid);
            check_disp_dut("c", bus_c.dig_en, bus_c.seg, b, 1'b0, 1'b0, valid);
            track_rot("a", bus_a.dig_en, prev_a, dwell_a, chg_a, 4);
            track_rot("c", bus_c.dig_en, prev_c, dwell_c, chg_c, 3);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_busy"},   32'(bus_a.busy),      32'd0);
        check_output({tag, "_bcd"},    32'(bus_a.bcd),       32'h000);
        check_output({tag, "_valid"},  32'(bus_a.bcd_valid), 32'd0);
        check_output({tag, "_dig_a"},  32'(bus_a.dig_en),    32'b001);
        check_output({tag, "_seg_a"},  32'(bus_a.seg),       32'h00);
        check_output({tag, "_seg_b"},  32'(bus_b.seg),       32'h7F);
        check_output({tag, "_bcd_c"},  32'(bus_c.bcd),       32'h000);
        check_output({tag, "_seg_c"},  32'(bus_c.seg),       32'h00);
    endtask

    // One conversion; stray >= 0 pulses an extra load (value 42) on that busy cycle
    task automatic apply_stimulus(input logic [7:0] v, input logic [11:0] exp, input int stray);
        int guard;
        int cycles;
        logic [11:0] got;
        guard = 0;
        while (bus_a.busy && guard < 50) begin
            tick();
            guard++;
        end
        drive(v, 1'b1);
        exp_q.push_back(exp);
        tick();
        drive(v, 1'b0);
        cycles = 0;
        while (bus_a.busy && cycles < 40) begin
            check_output("bcd_hold", 32'(bus_a.bcd), 32'(last_bcd));
            if (cycles == stray) drive(8'd42, 1'b1);
            else                 drive(v, 1'b0);
            tick();
            cycles++;
        end
        drive(v, 1'b0);
        check_output("busy_len", 32'(cycles), 32'd8);
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check_output("bcd_a", 32'(bus_a.bcd), 32'(got));
            check_output("bcd_b", 32'(bus_b.bcd), 32'(got));
            check_output("bcd_c", 32'(bus_c.bcd), 32'(got));
            check_output("valid", 32'(bus_a.bcd_valid), 32'd1);
            last_bcd = got;
        end
        if (stray >= 0) begin
            tick();
            check_output("stray_ignored", 32'(bus_a.busy), 32'd0);
            tick();
            check_output("stray_bcd", 32'(bus_a.bcd), 32'(exp));
        end
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        vecs[0] = '{8'd255, 12'h255};
        vecs[1] = '{8'd0,   12'h000};
        vecs[2] = '{8'd7,   12'h007};
        vecs[3] = '{8'd100, 12'h100};
        vecs[4] = '{8'd42,  12'h042};
        vecs[5] = '{8'd99,  12'h099};
        vecs[6] = '{8'd10,  12'h010};
        vecs[7] = '{8'd128, 12'h128};
        vecs[8] = '{8'd9,   12'h009};
        vecs[9] = '{8'd205, 12'h205};
        last_bcd = 12'h000;

        drive(8'd0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b0;
        check_display(12'h000, 1'b0);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].value, vecs[i].exp_bcd, -1);
            check_display(vecs[i].exp_bcd, 1'b1);
        end

        $display("[TB] load during conversion");
        apply_stimulus(8'd100, 12'h100, 3);
        check_display(12'h100, 1'b1);

        $display("[TB] reset mid-conversion");
        drive(8'd200, 1'b1);
        tick();
        drive(8'd200, 1'b0);
        check_output("abort_busy_before", 32'(bus_a.busy), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        check_reset_state("abort");
        rst = 1'b0;
        last_bcd = 12'h000;
        for (int i = 0; i < 10; i++) tick();
        check_output("abort_no_update", 32'(bus_a.bcd), 32'h000);
        check_output("abort_valid", 32'(bus_a.bcd_valid), 32'd0);
        check_output("abort_busy", 32'(bus_a.busy), 32'd0);
        check_display(12'h000, 1'b0);

        apply_stimulus(8'd58, 12'h058, -1);
        check_display(12'h058, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
